// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states
// and the byte-mask helper used for strobe generation.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the addressed bytes out of a two-word
// window and sign- or zero-extends them to a full word.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [1:0]            off,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] window;

    // Size casts of signed values sign-extend; unsigned ones zero-extend.
    function automatic logic [DATA_WIDTH-1:0] extend(
        input logic [DATA_WIDTH-1:0] v,
        input logic [1:0]            sz,
        input logic                  uns
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = signed'(v[7:0]);
        h = signed'(v[15:0]);
        case (sz)
            SZ_BYTE: extend = uns ? DATA_WIDTH'(v[7:0])  : DATA_WIDTH'(b);
            SZ_HALF: extend = uns ? DATA_WIDTH'(v[15:0]) : DATA_WIDTH'(h);
            default: extend = v;
        endcase
    endfunction

    always_comb begin
        window = DATA_WIDTH'({hi, lo} >> {off, 3'b000});
        result = extend(window, size, is_unsigned);
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for one byte-strobed data memory port; splits
// misaligned accesses into two word accesses and returns one response.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 256,
    parameter int TRANSFER_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [1:0]                req_size_i,
    input  logic                      req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    output logic                      rsp_valid_o,
    output logic                      rsp_err_o,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [TRANSFER_WIDTH-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    // Word index carries one extra bit so the +1 for the second word cannot wrap.
    localparam int               IDX_W = ADDR_WIDTH - 1;
    localparam logic [IDX_W-1:0] DEPTH = IDX_W'(MEM_DEPTH);

    lsu_state_t state, state_nxt;

    logic                  accept;
    logic [7:0]            sh_in;
    logic [IDX_W-1:0]      idx0;
    logic [IDX_W-1:0]      idx1;
    logic                  err_in;

    logic [ADDR_WIDTH-3:0] word_q;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  we_q;
    logic                  err_q;
    logic [7:0]            sh_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] load_res;

    always_comb begin
        accept = req_valid_i && (state == ST_IDLE);
        sh_in  = {4'b0000, size_mask(req_size_i)} << req_addr_i[1:0];
        idx0   = {1'b0, req_addr_i[ADDR_WIDTH-1:2]};
        idx1   = idx0 + IDX_W'(1);
        err_in = (req_size_i == SZ_ILL) || (idx0 >= DEPTH) ||
                 ((|sh_in[7:4]) && ((idx1 >= DEPTH) || idx1[IDX_W-1]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= err_in;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            word_q  <= req_addr_i[ADDR_WIDTH-1:2];
            off_q   <= req_addr_i[1:0];
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            we_q    <= req_we_i;
            sh_q    <= sh_in;
            wdata_q <= req_wdata_i;
        end
        if (state == ST_ACC0) begin
            lo_q <= mem_rdata_i;
            hi_q <= '0;
        end
        if (state == ST_ACC1) begin
            hi_q <= mem_rdata_i;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = err_in ? ST_DONE : ST_ACC0;
            ST_ACC0: state_nxt = (|sh_q[7:4]) ? ST_ACC1 : ST_DONE;
            ST_ACC1: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = rst_n && (state == ST_IDLE);
        rsp_valid_o = 1'b0;
        rsp_err_o   = 1'b0;
        rsp_rdata_o = '0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        case (state)
            ST_ACC0: begin
                mem_we_o    = we_q;
                mem_addr_o  = {word_q, 2'b00};
                mem_be_o    = sh_q[3:0];
                mem_wdata_o = wdata_q << {off_q, 3'b000};
            end
            ST_ACC1: begin
                mem_we_o    = we_q;
                mem_addr_o  = {word_q + 1'b1, 2'b00};
                mem_be_o    = sh_q[7:4];
                mem_wdata_o = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
            end
            ST_DONE: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
                rsp_rdata_o = (err_q || we_q) ? '0 : load_res;
            end
            default: ;
        endcase
    end

    lsu_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .lo         (lo_q),
        .hi         (hi_q),
        .off        (off_q),
        .size       (size_q),
        .is_unsigned(uns_q),
        .result     (load_res)
    );

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-level reference memory model, per-cycle
// compare process, directed literal scenarios and randomized traffic.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [9:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    lsu_mem_master #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(256), .TRANSFER_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    // Word-organised memory attached to the DUT port, plus a preload path.
    logic [31:0] mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    assign mem_rdata_i = mem[mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_we_o) begin
            for (int j = 0; j < 4; j++)
                if (mem_be_o[j]) mem[mem_addr_o[9:2]][8*j +: 8] <= mem_wdata_o[8*j +: 8];
        end
    end

    // Reference model: flat byte array and per-request expectations.
    logic [7:0] ref_mem [0:1023];

    typedef struct packed {
        logic        err;
        logic        split;
        logic        we;
        logic [1:0]  lat;
        logic [31:0] rdata;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [9:0]  a0;
        logic [9:0]  a1;
        logic [31:0] wd0;
        logic [31:0] wd1;
    } exp_t;

    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [9:0] a, input logic [31:0] wd);
        exp_t e;
        int n, off, w0, b;
        logic [63:0] v;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a) % 4;
        w0  = int'(a) / 4;
        e = '0;
        e.we    = we;
        e.split = (off + n > 4);
        e.err   = (sz == 2'd3) || (w0 >= 256) || ((int'(a) + n - 1) / 4 >= 256);
        e.lat   = e.err ? 2'd1 : (e.split ? 2'd3 : 2'd2);
        e.a0    = 10'(w0 * 4);
        e.a1    = 10'(w0 * 4 + 4);
        for (int i = 0; i < n; i++) begin
            b = int'(a) + i;
            if (b / 4 == w0) e.be0[b % 4] = 1'b1;
            else             e.be1[b % 4] = 1'b1;
        end
        for (int j = 0; j < 4; j++) begin
            if (j >= off) e.wd0[8*j +: 8] = wd[8*(j-off) +: 8];
            else          e.wd1[8*j +: 8] = wd[8*(j+4-off) +: 8];
        end
        if (!we && !e.err) begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
            if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
            e.rdata = v[31:0];
        end
        return e;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    int          total = 0;
    int          bad = 0;
    int          rsp_cnt = 0;
    int          last_lat;
    logic [31:0] last_rdata, last_wd0, last_wd1;
    logic        last_err;
    logic [3:0]  last_be0, last_be1;
    logic [9:0]  last_a0, last_a1;
    logic        chk_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model's expectations.
    initial begin : compare
        exp_t ce;
        logic busy, acc_exp, rsp_exp;
        int   k;
        busy = 1'b0;
        k    = 0;
        ce   = '0;
        forever begin
            @(negedge clk);
            if (pre_en)
                for (int j = 0; j < 4; j++) ref_mem[4*int'(pre_idx) + j] = pre_val[8*j +: 8];
            if (!rst_n || !chk_en) begin
                busy = 1'b0;
            end else begin
                if (busy) k++;
                acc_exp = busy && !ce.err && (k == 1 || (k == 2 && ce.split));
                rsp_exp = busy && (k == int'(ce.lat));
                chk("ready", req_ready_o, !busy);
                chk("rsp_valid", rsp_valid_o, rsp_exp);
                if (rsp_valid_o && busy) begin
                    rsp_cnt++;
                    last_lat   = k;
                    last_rdata = rsp_rdata_o;
                    last_err   = rsp_err_o;
                end
                if (busy && k == 1) begin
                    last_be0 = mem_be_o; last_a0 = mem_addr_o; last_wd0 = mem_wdata_o;
                end
                if (busy && k == 2) begin
                    last_be1 = mem_be_o; last_a1 = mem_addr_o; last_wd1 = mem_wdata_o;
                end
                if (rsp_exp) begin
                    chk("rsp_err", rsp_err_o, ce.err);
                    chk("rsp_rdata", rsp_rdata_o, ce.rdata);
                    if (ce.we && !ce.err) begin
                        chk("mem_word0", mem[ce.a0[9:2]], ref_word(int'(ce.a0[9:2])));
                        if (ce.split) chk("mem_word1", mem[ce.a1[9:2]], ref_word(int'(ce.a1[9:2])));
                    end
                end else begin
                    chk("rsp_err_idle", rsp_err_o, 0);
                    chk("rsp_rdata_idle", rsp_rdata_o, 0);
                end
                if (acc_exp) begin
                    chk("mem_we", mem_we_o, ce.we);
                    chk("mem_addr", mem_addr_o, (k == 1) ? ce.a0 : ce.a1);
                    chk("mem_be", mem_be_o, (k == 1) ? ce.be0 : ce.be1);
                    chk("mem_wdata", mem_wdata_o, (k == 1) ? ce.wd0 : ce.wd1);
                end else begin
                    chk("mem_we_idle", mem_we_o, 0);
                    chk("mem_addr_idle", mem_addr_o, 0);
                    chk("mem_be_idle", mem_be_o, 0);
                    chk("mem_wdata_idle", mem_wdata_o, 0);
                end
                if (busy && k >= int'(ce.lat)) busy = 1'b0;
                if (req_valid_i && req_ready_o) begin
                    ce = model(req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i);
                    if (req_we_i && !ce.err) begin
                        for (int i = 0; i < 4; i++)
                            if (i < ((req_size_i == 2'd0) ? 1 : (req_size_i == 2'd1) ? 2 : 4))
                                ref_mem[int'(req_addr_i) + i] = req_wdata_i[8*i +: 8];
                    end
                    busy = 1'b1;
                    k    = 0;
                end
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = 8'(idx);
        pre_val = val;
        @(posedge clk); #1;
        pre_en  = 1'b0;
    endtask

    // Called just after a rising edge with the DUT idle; returns in the cycle after the response.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [9:0] a, input logic [31:0] wd);
        exp_t e;
        e = model(we, sz, uns, a, wd);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
        req_unsigned_i = uns; req_addr_i = a; req_wdata_i = wd;
        @(posedge clk); #1;
        req_valid_i = 1'b0; req_we_i = 1'($urandom); req_size_i = 2'($urandom);
        req_unsigned_i = 1'($urandom); req_addr_i = 10'($urandom); req_wdata_i = $urandom;
        repeat (int'(e.lat)) @(posedge clk);
        #1;
    endtask

    task automatic run_lit(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [9:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input int exp_lat);
        int c0;
        c0 = rsp_cnt;
        issue(we, sz, uns, a, wd);
        chk({nm, "_rsp_count"}, 32'(rsp_cnt - c0), 1);
        chk({nm, "_rdata"}, last_rdata, exp_rd);
        chk({nm, "_latency"}, 32'(last_lat), 32'(exp_lat));
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ready"}, req_ready_o, 0);
        chk({nm, "_rsp_valid"}, rsp_valid_o, 0);
        chk({nm, "_rsp_err"}, rsp_err_o, 0);
        chk({nm, "_rsp_rdata"}, rsp_rdata_o, 0);
        chk({nm, "_mem_we"}, mem_we_o, 0);
        chk({nm, "_mem_addr"}, mem_addr_o, 0);
        chk({nm, "_mem_wdata"}, mem_wdata_o, 0);
        chk({nm, "_mem_be"}, mem_be_o, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "time limit");
    end

    initial begin : driver
        rst_n = 1'b0; chk_en = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = '0;
        req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready_o, 1);
        @(posedge clk); #1;
        chk_en = 1'b1;

        for (int w = 2; w < 256; w++) preload(w, $urandom);
        preload(0, 32'h44332211);
        preload(1, 32'h88776655);

        run_lit("lw_000", 1'b0, 2'b10, 1'b0, 10'h000, 32'h0, 32'h44332211, 2);
        chk("lw_000_be0", last_be0, 4'b1111);
        run_lit("lb_007", 1'b0, 2'b00, 1'b0, 10'h007, 32'h0, 32'hFFFFFF88, 2);
        run_lit("lbu_007", 1'b0, 2'b00, 1'b1, 10'h007, 32'h0, 32'h00000088, 2);
        run_lit("lh_002", 1'b0, 2'b01, 1'b0, 10'h002, 32'h0, 32'h00004433, 2);
        run_lit("lw_002", 1'b0, 2'b10, 1'b0, 10'h002, 32'h0, 32'h66554433, 3);
        chk("lw_002_a0", last_a0, 10'h000);
        chk("lw_002_be0", last_be0, 4'b1100);
        chk("lw_002_a1", last_a1, 10'h004);
        chk("lw_002_be1", last_be1, 4'b0011);

        run_lit("sh_003", 1'b1, 2'b01, 1'b0, 10'h003, 32'h0000BEEF, 32'h0, 3);
        chk("sh_003_a0", last_a0, 10'h000);
        chk("sh_003_be0", last_be0, 4'b1000);
        chk("sh_003_wd0", last_wd0, 32'hEF000000);
        chk("sh_003_a1", last_a1, 10'h004);
        chk("sh_003_be1", last_be1, 4'b0001);
        chk("sh_003_wd1", last_wd1, 32'h000000BE);
        chk("sh_003_word0", mem[0], 32'hEF332211);
        chk("sh_003_word1", mem[1], 32'h887766BE);

        run_lit("lw_3fe_err", 1'b0, 2'b10, 1'b0, 10'h3FE, 32'h0, 32'h0, 1);
        chk("lw_3fe_err_flag", last_err, 1);
        run_lit("size11_err", 1'b0, 2'b11, 1'b0, 10'h000, 32'h0, 32'h0, 1);
        chk("size11_err_flag", last_err, 1);

        // Reset while the second half of a split store is on the port.
        preload(0, 32'h44332211);
        preload(1, 32'h88776655);
        chk_en = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b01;
        req_unsigned_i = 1'b0; req_addr_i = 10'h003; req_wdata_i = 32'h0000BEEF;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_acc1_we", mem_we_o, 1);
        chk("rst_acc1_be", mem_be_o, 4'b0001);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        check_zero("rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", req_ready_o, 1);
        chk("rst_word0", mem[0], 32'hEF332211);
        chk("rst_word1", mem[1], 32'h88776655);
        @(posedge clk); #1;
        preload(0, 32'hEF332211);
        preload(1, 32'h88776655);
        chk_en = 1'b1;
        run_lit("lw_004_after_rst", 1'b0, 2'b10, 1'b0, 10'h004, 32'h0, 32'h88776655, 2);

        for (int t = 0; t < 300; t++) begin
            logic [9:0] a;
            logic [1:0] sz;
            a  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1008, 1023))
                                             : 10'($urandom_range(0, 63));
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            issue(1'($urandom), sz, 1'($urandom), a, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the data memory's word-organised, byte-strobed port (`we`, `addr`, `data_in`, `write_transfer`, `data_out`).
- Takes one byte/half/word request from the core pipeline or the crypto co-processor.
- Generates byte strobes and lane-aligned write data, and splits misaligned accesses into two word accesses.
- Reassembles and sign/zero-extends load data, then returns a single response.
- Sits between the requester and one port of the dual-port data memory.

Parameters:
- ADDR_WIDTH, 10, byte-address width of the memory port.
- DATA_WIDTH, 32, word width. Only 32 is supported.
- MEM_DEPTH, 256, number of words in the target memory.
- TRANSFER_WIDTH, 4, byte-strobe width (DATA_WIDTH/8).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  zero-extend load result
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wdata_i  in  DATA_WIDTH  store data, right-justified
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_err_o  out  1  request rejected (qualified by rsp_valid_o)
- rsp_rdata_o  out  DATA_WIDTH  load result; 0 for stores and errors
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  word-aligned byte address (bits[1:0] = 0)
- mem_wdata_o  out  DATA_WIDTH  lane-aligned write data
- mem_be_o  out  TRANSFER_WIDTH  byte strobes (to memory write_transfer)
- mem_rdata_i  in  DATA_WIDTH  memory read data (combinational, valid in the same cycle)

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - All outputs 0, except req_ready_o = 1 once rst_n deasserts.
  - Any in-flight second access is abandoned.
- FSM states: IDLE, ACC0, ACC1, DONE.
- req_ready_o = (state == IDLE). A request is accepted on a clk edge with req_valid_i && req_ready_o. Address, size, unsigned flag and data are registered at accept.
- At accept:
  - off = addr[1:0].
  - mask = 0001 (byte) / 0011 (half) / 1111 (word).
  - sh = mask << off, 8 bits wide.
  - split = |sh[7:4].
- Error at accept, if any of these hold:
  - size == 11;
  - first word index (addr >> 2) >= MEM_DEPTH;
  - split and second word index >= MEM_DEPTH, or the +4 address overflows ADDR_WIDTH (no wrap to 0).
  - On error: IDLE -> DONE directly, no memory access, rsp_err_o = 1, rsp_rdata_o = 0.
- Otherwise IDLE -> ACC0.
- ACC0:
  - mem_addr_o = {addr[ADDR_WIDTH-1:2], 00}.
  - mem_be_o = sh[3:0].
  - mem_wdata_o = wdata << 8*off.
  - mem_we_o = req_we.
  - Capture mem_rdata_i into lo.
  - Go to ACC1 if split, else DONE.
- ACC1:
  - mem_addr_o = first address + 4.
  - mem_be_o = sh[7:4].
  - mem_wdata_o = wdata >> 8*(4-off).
  - mem_we_o = req_we.
  - Capture mem_rdata_i into hi. Go to DONE.
- DONE:
  - rsp_valid_o = 1 for exactly one cycle, then IDLE.
  - Load result: take ({hi, lo} >> 8*off), select the low 8/16/32 bits, then sign-extend (or zero-extend when unsigned). For non-split accesses, hi = 0.
- Latency from accept edge to rsp_valid_o high:
  - aligned or non-crossing: 2 cycles;
  - split: 3 cycles;
  - error: 1 cycle.
- Back-to-back: a new request can be accepted in the cycle after DONE, so throughput is one request per 3 cycles (aligned).
- Outside ACC0/ACC1: mem_we_o = 0, mem_be_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
- Split store: both halves are written; there is no atomicity beyond reset. A reset in ACC1 leaves the first half written.
- req_* inputs are ignored when not accepted. Changes to req_* after accept have no effect.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state enum lsu_state_t;
  - the byte-mask function.
- One sub-module, lsu_load_align: combinational {hi, lo}/off/size/unsigned -> extended result. It is reused by the co-processor's stream reader.

Test Plan:
- Memory preload for all scenarios: word0 = 0x44332211, word1 = 0x88776655.
- LW addr 0x000: rsp_valid 2 cycles after accept; rdata 0x44332211; mem_we_o never high; mem_be_o = 1111 in ACC0.
- LB addr 0x007 -> rdata 0xFFFFFF88. LBU addr 0x007 -> 0x00000088. LH addr 0x002 -> 0x00004433.
- LW addr 0x002:
  - accesses at 0x000 (be 1100) then 0x004 (be 0011);
  - rdata 0x66554433; rsp 3 cycles after accept.
- SH wdata 0x0000BEEF addr 0x003:
  - ACC0: addr 0x000, be 1000, wdata 0xEF000000;
  - ACC1: addr 0x004, be 0001, wdata low byte 0xBE;
  - result: word0 = 0xEF332211, word1 = 0x887766BE.
- LW addr 0x3FE, and size 11 at addr 0x000: rsp_err = 1, rdata 0, 1-cycle latency, no memory access.
- Reset pulse in ACC1 of the split store above: word1 unchanged; all outputs 0 during reset; req_ready_o = 1 after release; next LW 0x004 returns 0x88776655.
